auth_initiator: RTL

Initiator-side request engine for the USB Type-C authentication driver. It sits directly upstream of the `responder` block. It builds a GET_DIGESTS, GET_CERTIFICATE or CHALLENGE request message and drives the request/message/ack handshake to the responder. It then captures and classifies the response, and reports completion and status to the host-side controller. It enforces its own response timeout.

---
 rtl/auth_initiator_pkg.sv | 43 ++++
 rtl/auth_initiator_if.sv | 22 ++
 rtl/auth_resp_classifier.sv | 25 ++
 rtl/auth_initiator.sv | 109 ++++++++++
 4 files changed

// File: rtl/auth_initiator_pkg.sv
// Shared constants for the authentication initiator: header field widths, message
// codes, status encodings and the one-hot state encoding.
package auth_initiator_pkg;

   localparam int SIZE_OF_HEADER_VARS = 8;
   localparam int SIZE_OF_HEADER_BYTES = 4;
   localparam int MSG_LEN_DEF = 64;
   localparam int SIZE_OF_STATES_INIT = 5;

   localparam logic [7:0] PROTO_VERSION = 8'h01;

   localparam logic [7:0] TYPE_GET_DIGESTS = 8'd129;
   localparam logic [7:0] TYPE_GET_CERTIFICATE = 8'd130;
   localparam logic [7:0] TYPE_CHALLENGE = 8'd131;

   localparam logic [7:0] RESP_DIGESTS = 8'h01;
   localparam logic [7:0] RESP_CERTIFICATE = 8'h02;
   localparam logic [7:0] RESP_CHALLENGE_AUTH = 8'h03;
   localparam logic [7:0] RESP_ERROR = 8'h7F;

   localparam logic [1:0] KIND_ILLEGAL = 2'd3;

   localparam logic [1:0] ST_OK = 2'd0;
   localparam logic [1:0] ST_ERROR_RESP = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_BAD_RESP = 2'd3;

   localparam logic [SIZE_OF_STATES_INIT-1:0] S_IDLE = 5'b00001;
   localparam logic [SIZE_OF_STATES_INIT-1:0] S_SEND = 5'b00010;
   localparam logic [SIZE_OF_STATES_INIT-1:0] S_WAIT_RESP = 5'b00100;
   localparam logic [SIZE_OF_STATES_INIT-1:0] S_ACK = 5'b01000;
   localparam logic [SIZE_OF_STATES_INIT-1:0] S_DONE = 5'b10000;

   // Only called for legal kinds; the illegal kind never builds a message.
   function automatic logic [7:0] kind_to_type(input logic [1:0] kind);
      case (kind)
         2'd0:    return TYPE_GET_DIGESTS;
         2'd1:    return TYPE_GET_CERTIFICATE;
         default: return TYPE_CHALLENGE;
      endcase
   endfunction

endpackage

// File: rtl/auth_initiator_if.sv
// Request/response handshake between the initiator (master) and the responder (slave).
interface auth_initiator_if
   import auth_initiator_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEF
);
   logic               resp_req_in;
   logic [MSG_LEN-1:0] auth_msg_resp_in;
   logic               resp_req_out;
   logic [MSG_LEN-1:0] auth_msg_resp_out;
   logic               Ack_in;

   modport master (
      output resp_req_in, auth_msg_resp_in, Ack_in,
      input  resp_req_out, auth_msg_resp_out
   );

   modport slave (
      input  resp_req_in, auth_msg_resp_in, Ack_in,
      output resp_req_out, auth_msg_resp_out
   );
endinterface

// File: rtl/auth_resp_classifier.sv
// Combinational response header check: maps the response version/type against the
// outstanding request type onto a 2-bit completion status.
module auth_resp_classifier
   import auth_initiator_pkg::*;
#(
   parameter int HDR_VAR_W = SIZE_OF_HEADER_VARS
) (
   input  logic [HDR_VAR_W-1:0] req_type,
   input  logic [HDR_VAR_W-1:0] resp_version,
   input  logic [HDR_VAR_W-1:0] resp_type,
   output logic [1:0]           status
);

   always_comb begin
      // NOTE: default first so every path assigns status and no latch is inferred.
      status = ST_BAD_RESP;
      if (resp_version != HDR_VAR_W'(PROTO_VERSION))
         status = ST_BAD_RESP;
      else if (resp_type == HDR_VAR_W'(RESP_ERROR))
         status = ST_ERROR_RESP;
      else if (resp_type == req_type - HDR_VAR_W'(128))
         status = ST_OK;
   end

endmodule

// File: rtl/auth_initiator.sv
// Initiator request engine: builds a request, runs the request/ack handshake with the
// responder, classifies the response and reports done/status with its own timeout.
module auth_initiator
   import auth_initiator_pkg::*;
#(
   parameter int MSG_LEN        = MSG_LEN_DEF,
   parameter int HDR_VAR_W      = SIZE_OF_HEADER_VARS,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [1:0]                   req_kind,
   input  logic [HDR_VAR_W-1:0]         req_param1,
   input  logic [HDR_VAR_W-1:0]         req_param2,
   input  logic [MSG_LEN-4*HDR_VAR_W-1:0] req_payload,
   auth_initiator_if.master             rsp,
   output logic                         busy,
   output logic                         done,
   output logic [1:0]                   status,
   output logic [MSG_LEN-1:0]           resp_msg
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [SIZE_OF_STATES_INIT-1:0] state;
   logic [CNT_W-1:0]               cnt;
   logic [1:0]                     cls_status;

   auth_resp_classifier #(.HDR_VAR_W(HDR_VAR_W)) u_classifier (
      .req_type     (rsp.auth_msg_resp_in[MSG_LEN-HDR_VAR_W-1 -: HDR_VAR_W]),
      .resp_version (rsp.auth_msg_resp_out[MSG_LEN-1 -: HDR_VAR_W]),
      .resp_type    (rsp.auth_msg_resp_out[MSG_LEN-HDR_VAR_W-1 -: HDR_VAR_W]),
      .status       (cls_status)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                <= S_IDLE;
         cnt                  <= '0;
         rsp.resp_req_in      <= 1'b0;
         rsp.auth_msg_resp_in <= '0;
         rsp.Ack_in           <= 1'b0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         status               <= ST_OK;
         resp_msg             <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  resp_msg <= '0;
                  if (req_kind == KIND_ILLEGAL) begin
                     status <= ST_BAD_RESP;
                     state  <= S_DONE;
                  end else begin
                     rsp.auth_msg_resp_in <= {HDR_VAR_W'(PROTO_VERSION),
                                              HDR_VAR_W'(kind_to_type(req_kind)),
                                              req_param1, req_param2, req_payload};
                     status <= ST_OK;
                     cnt    <= CNT_W'(TIMEOUT_CYCLES);
                     state  <= S_SEND;
                  end
               end
            end
            S_SEND: begin
               rsp.resp_req_in <= 1'b1;
               state           <= S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
               cnt <= cnt - 1'b1;
               // A response on the expiry edge takes priority over the timeout.
               if (rsp.resp_req_out) begin
                  resp_msg        <= rsp.auth_msg_resp_out;
                  status          <= cls_status;
                  rsp.resp_req_in <= 1'b0;
                  state           <= S_ACK;
               end else if (cnt <= CNT_W'(1)) begin
                  status          <= ST_TIMEOUT;
                  rsp.resp_req_in <= 1'b0;
                  state           <= S_DONE;
               end
            end
            S_ACK: begin
               rsp.Ack_in <= 1'b1;
               if (!rsp.resp_req_out)
                  state <= S_DONE;
            end
            S_DONE: begin
               rsp.Ack_in <= 1'b0;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               rsp.resp_req_in <= 1'b0;
               rsp.Ack_in      <= 1'b0;
               busy            <= 1'b0;
               state           <= S_IDLE;
            end
         endcase
      end
   end

endmodule
